// File: rtl/mem_access_pkg.sv
// mem_access_pkg: MEM-stage op codes, bus widths, FSM states and op-class helpers
package mem_access_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int RADDR_W = 5;
  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  function automatic logic is_load(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return is_load(op) || is_store(op);
  endfunction
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    return (op inside {MEM_LH, MEM_LHU, MEM_SH} && a[0]) ||
           (op inside {MEM_LW, MEM_SW} && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: word-addressed data bus with a req/ack handshake
interface mem_access_if;
  import mem_access_pkg::*;
  logic              dbus_req_o;
  logic              dbus_we_o;
  logic [ADDR_W-1:0] dbus_addr_o;
  logic [3:0]        dbus_be_o;
  logic [DATA_W-1:0] dbus_wdata_o;
  logic              dbus_ack_i;
  logic [DATA_W-1:0] dbus_rdata_i;
  modport master (
    output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
    input  dbus_ack_i, dbus_rdata_i
  );
  modport slave (
    input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o,
    output dbus_ack_i, dbus_rdata_i
  );
endinterface

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: selects the addressed byte/half of a read word and extends it
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  mem_op_e           i_op,
  input  logic [1:0]        i_a,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_data
);
  logic [15:0] w_s;
  always_comb begin
    w_s = 16'(i_rdata >> {i_a, 3'b000});
    o_data = i_op == MEM_LB  ? {{24{w_s[7]}}, w_s[7:0]} :
             i_op == MEM_LBU ? {24'd0, w_s[7:0]} :
             i_op == MEM_LH  ? {{16{w_s[15]}}, w_s} :
             i_op == MEM_LHU ? {16'd0, w_s} :
                               i_rdata;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage driving the data bus and registering the MEM/WB write-back
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [3:0]         mem_op_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_data_i,
  input  logic               mem_we_i,
  input  logic               reg_we_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic [DATA_W-1:0]  reg_wdata_i,
  mem_access_if.master       dbus,
  output logic               stall_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic [DATA_W-1:0]  reg_wdata_o,
  output logic               misalign_o,
  output logic               bus_err_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  state_e             r_state, w_next;
  mem_op_e            r_op;
  logic [1:0]         r_a;
  logic [RADDR_W-1:0] r_waddr;
  logic [ADDR_W-3:0]  r_word;
  logic [3:0]         r_be;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_we;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_mem, w_fault, w_mis, w_start, w_timeout, w_ack;
  logic [3:0]         w_be;
  logic [DATA_W-1:0]  w_wdata, w_ld;

  assign w_ack     = dbus.dbus_ack_i;
  assign w_mem     = is_mem(mem_op_i);
  // The instruction that just faulted is still presented during the pulse cycle; it is dropped, not retried.
  assign w_fault   = misalign_o | bus_err_o;
  assign w_mis     = is_misaligned(mem_op_i, mem_addr_i[1:0]);
  assign w_start   = r_state == ST_IDLE && w_mem && !w_fault && !w_mis;
  assign w_timeout = r_state == ST_BUSY && !w_ack && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);

  assign dbus.dbus_req_o   = r_state == ST_BUSY;
  assign dbus.dbus_we_o    = r_we;
  assign dbus.dbus_addr_o  = {r_word, 2'b00};
  assign dbus.dbus_be_o    = r_be;
  assign dbus.dbus_wdata_o = r_wdata;

  always_comb begin
    w_next  = r_state;
    stall_o = 1'b0;
    w_next  = r_state == ST_IDLE ? (w_start ? ST_BUSY : ST_IDLE) :
              r_state == ST_BUSY ? (w_ack ? ST_DONE : w_timeout ? ST_IDLE : ST_BUSY) :
                                   ST_IDLE;
    stall_o = r_state == ST_BUSY || (r_state == ST_IDLE && w_mem && !w_fault);
  end

  always_comb begin
    w_be    = mem_op_i == MEM_SB ? 4'b0001 << mem_addr_i[1:0] :
              mem_op_i == MEM_SH ? (mem_addr_i[1] ? 4'b1100 : 4'b0011) :
                                   4'hF;
    w_wdata = mem_op_i == MEM_SB ? {4{mem_data_i[7:0]}} :
              mem_op_i == MEM_SH ? {2{mem_data_i[15:0]}} :
                                   mem_data_i;
  end

  mem_access_load_align u_load_align (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_rdata(dbus.dbus_rdata_i),
    .o_data (w_ld)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (r_state == ST_BUSY && !w_ack && !w_timeout) ? r_cnt + 1'b1 : '0;
      misalign_o <= r_state == ST_IDLE && w_mem && !w_fault && w_mis;
      bus_err_o  <= w_timeout;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_op    <= MEM_NOP;
      r_a     <= '0;
      r_waddr <= '0;
      r_word  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_start) begin
      r_op    <= mem_op_e'(mem_op_i);
      r_a     <= mem_addr_i[1:0];
      r_waddr <= reg_waddr_i;
      r_word  <= mem_addr_i[ADDR_W-1:2];
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_we    <= is_store(mem_op_i) & mem_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_we_o    <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else if (r_state == ST_IDLE && !w_mem) begin
      reg_we_o    <= reg_we_i;
      reg_waddr_o <= reg_waddr_i;
      reg_wdata_o <= reg_wdata_i;
    end else if (r_state == ST_BUSY && w_ack) begin
      reg_we_o    <= is_load(r_op);
      reg_waddr_o <= r_waddr;
      reg_wdata_o <= w_ld;
    end else begin
      reg_we_o    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized MEM-stage accesses against a byte-lane reference model
module tb_mem_access;
  import mem_access_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr, mem_data, reg_wdata;
  logic        mem_we, reg_we;
  logic [4:0]  reg_waddr;
  logic        stall, wb_we, mis, err;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  int errs = 0, checks = 0;
  int          o_nstall, o_nreq;
  bit          o_done;
  logic [31:0] o_baddr, o_wdata, o_wb_wd;
  logic [3:0]  o_be;
  logic        o_bwe, o_wb_we, o_mis, o_err;
  logic [4:0]  o_wb_wa;
  logic [3:0]  ops [8] = '{MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};

  mem_access_if bus ();
  mem_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .mem_we_i(mem_we), .reg_we_i(reg_we), .reg_waddr_i(reg_waddr), .reg_wdata_i(reg_wdata), .dbus(bus),
    .stall_o(stall), .reg_we_o(wb_we), .reg_waddr_o(wb_wa), .reg_wdata_o(wb_wd),
    .misalign_o(mis), .bus_err_o(err)
  );
  always #5 clk = ~clk;

  function automatic bit st_op(input logic [3:0] op);
    return op == MEM_SB || op == MEM_SH || op == MEM_SW;
  endfunction
  function automatic int op_size(input logic [3:0] op);
    return (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 1 :
           (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2 : 4;
  endfunction
  function automatic logic [31:0] ref_load(input logic [3:0] op, input int a, input logic [31:0] rd);
    logic [31:0] s, b, h;
    s = rd >> (8 * a);
    b = s % 256;
    h = s % 65536;
    case (op)
      MEM_LB:  return b >= 128 ? b - 256 : b;
      MEM_LBU: return b;
      MEM_LH:  return h >= 32768 ? h - 65536 : h;
      MEM_LHU: return h;
      default: return rd;
    endcase
  endfunction
  function automatic logic [3:0] ref_be(input logic [3:0] op, input int a);
    return op == MEM_SB ? 4'(1 << a) : op == MEM_SH ? 4'(3 << a) : 4'hF;
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
    return op == MEM_SB ? (d % 256) * 32'h01010101 : op == MEM_SH ? (d % 65536) * 32'h00010001 : d;
  endfunction

  // Presents one instruction at a negedge, plays the bus slave, and records what the stage did.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, data, input logic [4:0] wa,
                         input int ack_after, input logic [31:0] rdata);
    int busy = 0;
    o_nstall = 0; o_nreq = 0; o_done = 0; o_baddr = '0; o_be = '0; o_wdata = '0; o_bwe = 0;
    o_wb_we = 0; o_wb_wa = '0; o_wb_wd = '0; o_mis = 0; o_err = 0;
    mem_op = op; mem_addr = addr; mem_data = data; mem_we = st_op(op); reg_we = !st_op(op);
    reg_waddr = wa; reg_wdata = $urandom;
    for (int c = 0; c < 40 && !o_done; c++) begin
      #1;
      bus.dbus_ack_i = 1'b0;
      if (bus.dbus_req_o) begin
        if (busy == 0) begin
          o_baddr = bus.dbus_addr_o; o_be = bus.dbus_be_o; o_wdata = bus.dbus_wdata_o; o_bwe = bus.dbus_we_o;
        end
        bus.dbus_ack_i = (busy == ack_after);
        bus.dbus_rdata_i = (busy == ack_after) ? rdata : $urandom;
        busy++;
        o_nreq++;
      end
      if (stall) o_nstall++;
      else begin
        o_wb_we = wb_we; o_wb_wa = wb_wa; o_wb_wd = wb_wd; o_mis = mis; o_err = err; o_done = 1;
      end
      @(negedge clk);
    end
    mem_op = MEM_NOP; reg_we = 1'b0; mem_we = 1'b0; bus.dbus_ack_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_op = MEM_NOP; mem_addr = '0; mem_data = '0; mem_we = 0; reg_we = 0;
    reg_waddr = '0; reg_wdata = '0; bus.dbus_ack_i = 0; bus.dbus_rdata_i = '0;
    #12;
    checks++; if (bus.dbus_req_o !== 1'b0) begin errs++; $display("FAIL reset_req got=%b exp=0", bus.dbus_req_o); end
    checks++; if ({wb_we, wb_wa, wb_wd} !== 38'd0) begin errs++; $display("FAIL reset_wb got=%b/%h/%h exp=0", wb_we, wb_wa, wb_wd); end
    checks++; if ({mis, err, stall} !== 3'b000) begin errs++; $display("FAIL reset_flags got=%b exp=000", {mis, err, stall}); end
    checks++; if ({bus.dbus_we_o, bus.dbus_be_o, bus.dbus_addr_o, bus.dbus_wdata_o} !== 69'd0) begin errs++; $display("FAIL reset_bus got=%h/%h/%h exp=0", bus.dbus_be_o, bus.dbus_addr_o, bus.dbus_wdata_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw;
    run_mem(MEM_LW, 32'h100, 32'h0, 5'd9, 0, 32'hDEADBEEF);
    checks++; if (o_done !== 1'b1) begin errs++; $display("FAIL lw_done got=%b exp=1", o_done); end
    checks++; if (o_nstall !== 2) begin errs++; $display("FAIL lw_stall got=%0d exp=2", o_nstall); end
    checks++; if (o_nreq !== 1) begin errs++; $display("FAIL lw_req got=%0d exp=1", o_nreq); end
    checks++; if ({o_baddr, o_be, o_bwe} !== {32'h100, 4'hF, 1'b0}) begin errs++; $display("FAIL lw_bus got=%h/%h/%b exp=100/f/0", o_baddr, o_be, o_bwe); end
    checks++; if ({o_wb_we, o_wb_wa, o_wb_wd} !== {1'b1, 5'd9, 32'hDEADBEEF}) begin errs++; $display("FAIL lw_wb got=%b/%0d/%h exp=1/9/deadbeef", o_wb_we, o_wb_wa, o_wb_wd); end
  endtask

  task automatic test_load_ext;
    run_mem(MEM_LB, 32'h103, 32'h0, 5'd1, 0, 32'h80FF0000);
    checks++; if (o_wb_wd !== 32'hFFFFFF80) begin errs++; $display("FAIL lb got=%h exp=ffffff80", o_wb_wd); end
    run_mem(MEM_LBU, 32'h103, 32'h0, 5'd2, 1, 32'h80FF0000);
    checks++; if (o_wb_wd !== 32'h00000080) begin errs++; $display("FAIL lbu got=%h exp=00000080", o_wb_wd); end
    checks++; if (o_nstall !== 3) begin errs++; $display("FAIL lbu_stall got=%0d exp=3", o_nstall); end
    run_mem(MEM_LHU, 32'h102, 32'h0, 5'd3, 0, 32'h80FF0000);
    checks++; if (o_wb_wd !== 32'h000080FF) begin errs++; $display("FAIL lhu got=%h exp=000080ff", o_wb_wd); end
    run_mem(MEM_LH, 32'h102, 32'h0, 5'd4, 0, 32'h80FF0000);
    checks++; if ({o_wb_we, o_wb_wd} !== {1'b1, 32'hFFFF80FF}) begin errs++; $display("FAIL lh got=%b/%h exp=1/ffff80ff", o_wb_we, o_wb_wd); end
  endtask

  task automatic test_store;
    run_mem(MEM_SB, 32'h101, 32'h12345678, 5'd0, 0, 32'h0);
    checks++; if ({o_be, o_wdata, o_bwe, o_baddr} !== {4'b0010, 32'h78787878, 1'b1, 32'h100}) begin errs++; $display("FAIL sb_bus got=%b/%h/%b/%h exp=0010/78787878/1/100", o_be, o_wdata, o_bwe, o_baddr); end
    checks++; if (o_wb_we !== 1'b0) begin errs++; $display("FAIL sb_wb got=%b exp=0", o_wb_we); end
    run_mem(MEM_SH, 32'h102, 32'h12345678, 5'd0, 0, 32'h0);
    checks++; if ({o_be, o_wdata} !== {4'b1100, 32'h56785678}) begin errs++; $display("FAIL sh_bus got=%b/%h exp=1100/56785678", o_be, o_wdata); end
    run_mem(MEM_SW, 32'h10C, 32'hA1B2C3D4, 5'd0, 2, 32'h0);
    checks++; if ({o_be, o_wdata, o_nstall} !== {4'hF, 32'hA1B2C3D4, 32'd4}) begin errs++; $display("FAIL sw got=%h/%h/%0d exp=f/a1b2c3d4/4", o_be, o_wdata, o_nstall); end
  endtask

  task automatic test_misalign;
    run_mem(MEM_LW, 32'h102, 32'h0, 5'd7, 0, 32'h0);
    checks++; if (o_nreq !== 0) begin errs++; $display("FAIL mis_req got=%0d exp=0", o_nreq); end
    checks++; if ({o_mis, o_err, o_wb_we} !== 3'b100) begin errs++; $display("FAIL mis_flags got=%b exp=100", {o_mis, o_err, o_wb_we}); end
    checks++; if (o_nstall !== 1) begin errs++; $display("FAIL mis_stall got=%0d exp=1", o_nstall); end
    run_mem(MEM_SH, 32'h101, 32'h0, 5'd0, 0, 32'h0);
    checks++; if ({o_mis, o_nreq} !== {1'b1, 32'd0}) begin errs++; $display("FAIL mis_sh got=%b/%0d exp=1/0", o_mis, o_nreq); end
    #1;
    checks++; if (mis !== 1'b0) begin errs++; $display("FAIL mis_pulse got=%b exp=0", mis); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    run_mem(MEM_LW, 32'h200, 32'h0, 5'd6, -1, 32'h0);
    checks++; if (o_nreq !== 16) begin errs++; $display("FAIL to_req got=%0d exp=16", o_nreq); end
    checks++; if (o_nstall !== 17) begin errs++; $display("FAIL to_stall got=%0d exp=17", o_nstall); end
    checks++; if ({o_err, o_mis, o_wb_we} !== 3'b100) begin errs++; $display("FAIL to_flags got=%b exp=100", {o_err, o_mis, o_wb_we}); end
    bus.dbus_ack_i = 1'b1; bus.dbus_rdata_i = $urandom;
    #1;
    checks++; if ({bus.dbus_req_o, err} !== 2'b00) begin errs++; $display("FAIL to_after got=%b exp=00", {bus.dbus_req_o, err}); end
    @(negedge clk);
    bus.dbus_ack_i = 1'b0;
    #1;
    checks++; if ({bus.dbus_req_o, wb_we, err} !== 3'b000) begin errs++; $display("FAIL late_ack got=%b exp=000", {bus.dbus_req_o, wb_we, err}); end
    @(negedge clk);
    run_mem(MEM_LW, 32'h204, 32'h0, 5'd8, 0, 32'h0BADF00D);
    checks++; if ({o_nstall, o_wb_we, o_wb_wd} !== {32'd2, 1'b1, 32'h0BADF00D}) begin errs++; $display("FAIL to_recover got=%0d/%b/%h exp=2/1/0badf00d", o_nstall, o_wb_we, o_wb_wd); end
  endtask

  task automatic test_nop;
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    pw = 0; pa = '0; pd = '0;
    for (int i = 0; i < 7; i++) begin
      mem_op = i[0] ? 4'(9 + i) : MEM_NOP;
      mem_addr = $urandom; reg_we = (i < 6) ? 1'($urandom) : 1'b0;
      reg_waddr = (i == 0) ? 5'd0 : 5'($urandom); reg_wdata = $urandom;
      if (i == 0) reg_we = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin errs++; $display("FAIL nop_stall i=%0d got=%b exp=0", i, stall); end
      if (i > 0) begin
        checks++; if ({wb_we, wb_wa, wb_wd} !== {pw, pa, pd}) begin errs++; $display("FAIL nop_pass i=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, wb_we, wb_wa, wb_wd, pw, pa, pd); end
      end
      pw = reg_we; pa = reg_waddr; pd = reg_wdata;
      @(negedge clk);
    end
    mem_op = MEM_NOP; reg_we = 1'b0;
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] addr, data, rd;
    logic [4:0]  wa;
    int          a, ack;
    bit          bad, st;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 7)];
      addr = $urandom; data = $urandom; rd = $urandom; wa = 5'($urandom); ack = $urandom_range(0, 3);
      a = int'(addr % 4); st = st_op(op); bad = (addr % op_size(op)) != 0;
      run_mem(op, addr, data, wa, ack, rd);
      checks++; if (o_done !== 1'b1) begin errs++; $display("FAIL rnd_done i=%0d got=%b exp=1", i, o_done); end
      checks++; if (o_nstall !== (bad ? 1 : ack + 2)) begin errs++; $display("FAIL rnd_stall i=%0d op=%0d got=%0d exp=%0d", i, op, o_nstall, bad ? 1 : ack + 2); end
      checks++; if (o_nreq !== (bad ? 0 : ack + 1)) begin errs++; $display("FAIL rnd_req i=%0d got=%0d exp=%0d", i, o_nreq, bad ? 0 : ack + 1); end
      checks++; if ({o_mis, o_err, o_wb_we} !== {bad, 1'b0, !bad && !st}) begin errs++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, {o_mis, o_err, o_wb_we}, {bad, 1'b0, !bad && !st}); end
      if (!bad) begin
        checks++; if ({o_baddr, o_be, o_bwe} !== {addr - addr % 4, ref_be(op, a), st}) begin errs++; $display("FAIL rnd_bus i=%0d op=%0d got=%h/%b/%b exp=%h/%b/%b", i, op, o_baddr, o_be, o_bwe, addr - addr % 4, ref_be(op, a), st); end
        if (st) begin
          checks++; if (o_wdata !== ref_wdata(op, data)) begin errs++; $display("FAIL rnd_wdata i=%0d op=%0d got=%h exp=%h", i, op, o_wdata, ref_wdata(op, data)); end
        end else begin
          checks++; if ({o_wb_wa, o_wb_wd} !== {wa, ref_load(op, a, rd)}) begin errs++; $display("FAIL rnd_load i=%0d op=%0d got=%0d/%h exp=%0d/%h", i, op, o_wb_wa, o_wb_wd, wa, ref_load(op, a, rd)); end
        end
      end
    end
  endtask

  task automatic test_reset_busy;
    mem_op = MEM_LW; mem_addr = 32'h300; reg_we = 1'b1; reg_waddr = 5'd3;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if ({bus.dbus_req_o, stall} !== 2'b11) begin errs++; $display("FAIL rb_busy got=%b exp=11", {bus.dbus_req_o, stall}); end
    #1;
    rst_n = 1'b0; mem_op = MEM_NOP; reg_we = 1'b0;
    #1;
    checks++; if ({bus.dbus_req_o, stall, mis, err} !== 4'b0000) begin errs++; $display("FAIL rb_req got=%b exp=0000", {bus.dbus_req_o, stall, mis, err}); end
    checks++; if ({wb_we, wb_wa, wb_wd, bus.dbus_addr_o, bus.dbus_be_o, bus.dbus_wdata_o, bus.dbus_we_o} !== 107'd0) begin errs++; $display("FAIL rb_outs got=%b/%0d/%h/%h exp=0", wb_we, wb_wa, wb_wd, bus.dbus_addr_o); end
    @(negedge clk);
    rst_n = 1'b1; mem_op = MEM_NOP; reg_we = 1'b1; reg_waddr = 5'd5; reg_wdata = 32'hA5A50001;
    #1;
    checks++; if (stall !== 1'b0) begin errs++; $display("FAIL rb_nop_stall got=%b exp=0", stall); end
    @(negedge clk);
    reg_we = 1'b0;
    #1;
    checks++; if ({wb_we, wb_wa, wb_wd} !== {1'b1, 5'd5, 32'hA5A50001}) begin errs++; $display("FAIL rb_nop got=%b/%0d/%h exp=1/5/a5a50001", wb_we, wb_wa, wb_wd); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_timeout();
    test_nop();
    test_random();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
